// File: rtl/irq_pending.sv
// Interrupt capture stage: sticky pending bits with per-line mask gating,
// acknowledge-by-code clearing and per-line overrun flags.
module irq_pending #(
  parameter int EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  input  logic       ack,
  input  logic [2:0] ack_code,
  output logic [7:0] req,
  output logic       irq,
  output logic [7:0] mask,
  output logic [7:0] overflow
);

  logic [7:0] irq_q;
  logic [7:0] pending_q;
  logic [7:0] mask_q;
  logic [7:0] overflow_q;

  logic [7:0] irq_d;
  logic [7:0] pending_d;
  logic [7:0] mask_d;
  logic [7:0] overflow_d;
  logic [7:0] set_s;
  logic [7:0] clr_s;

  // Next-state logic for capture, clear, overflow and mask
  always_comb begin
    irq_d      = irq_in;
    set_s      = 8'h00;
    clr_s      = 8'h00;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    mask_d     = mask_q;

    if (EDGE_MODE != 0) begin
      set_s = irq_in & ~irq_q;
    end else begin
      set_s = irq_in;
    end

    for (int i = 0; i < 8; i++) begin
      if (ack && (ack_code == 3'(i))) begin
        clr_s[i] = 1'b1;
      end else begin
        clr_s[i] = 1'b0;
      end

      // A new request on a line still pending is an overrun; set beats clear.
      if (set_s[i] && pending_q[i] && !clr_s[i]) begin
        overflow_d[i] = 1'b1;
      end else if (clr_s[i] && !set_s[i]) begin
        overflow_d[i] = 1'b0;
      end else begin
        overflow_d[i] = overflow_q[i];
      end
    end

    pending_d = set_s | (pending_q & ~clr_s);

    if (mask_we) begin
      mask_d = mask_wdata;
    end else begin
      mask_d = mask_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q      <= 8'h00;
      pending_q  <= 8'h00;
      mask_q     <= 8'hFF;
      overflow_q <= 8'h00;
    end else begin
      irq_q      <= irq_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
    end
  end

  assign req      = pending_q & mask_q;
  assign irq      = |(pending_q & mask_q);
  assign mask     = mask_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_pending.sv
// Scoreboard bench for irq_pending: an edge-mode and a level-mode instance
// share clock and reset; expected values are queued as stimulus is driven.
module tb_irq_pending;

  logic       clk;
  logic       rst_n;

  logic [7:0] e_irq_in, e_mask_wdata, e_req, e_mask, e_overflow;
  logic       e_mask_we, e_ack, e_irq;
  logic [2:0] e_ack_code;

  logic [7:0] l_irq_in, l_mask_wdata, l_req, l_mask, l_overflow;
  logic       l_mask_we, l_ack, l_irq;
  logic [2:0] l_ack_code;

  int checks;
  int errors;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  irq_pending #(.EDGE_MODE(1)) dut_edge (
    .clk(clk), .rst_n(rst_n), .irq_in(e_irq_in),
    .mask_we(e_mask_we), .mask_wdata(e_mask_wdata),
    .ack(e_ack), .ack_code(e_ack_code),
    .req(e_req), .irq(e_irq), .mask(e_mask), .overflow(e_overflow)
  );

  irq_pending #(.EDGE_MODE(0)) dut_level (
    .clk(clk), .rst_n(rst_n), .irq_in(l_irq_in),
    .mask_we(l_mask_we), .mask_wdata(l_mask_wdata),
    .ack(l_ack), .ack_code(l_ack_code),
    .req(l_req), .irq(l_irq), .mask(l_mask), .overflow(l_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    e_irq_in = 8'h00; e_mask_we = 1'b0; e_mask_wdata = 8'h00;
    e_ack = 1'b0; e_ack_code = 3'd0;
    l_irq_in = 8'h00; l_mask_we = 1'b0; l_mask_wdata = 8'h00;
    l_ack = 1'b0; l_ack_code = 3'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL reset_req got=%h exp=%h", e_req, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (e_mask !== exp_v) begin errors++; $display("FAIL reset_mask got=%h exp=%h", e_mask, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (e_overflow !== exp_v) begin errors++; $display("FAIL reset_overflow got=%h exp=%h", e_overflow, exp_v); end
    checks++;
    if (e_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", e_irq); end
    checks++;
    if (l_req !== 8'h00) begin errors++; $display("FAIL reset_lreq got=%h exp=00", l_req); end
  endtask

  task automatic test_capture_drain();
    e_irq_in = 8'h24; exp_q.push_back(8'h24);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL capture_req got=%h exp=%h", e_req, exp_v); end
    e_irq_in = 8'h00; e_ack = 1'b1; e_ack_code = 3'd5; exp_q.push_back(8'h04);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL ack5_req got=%h exp=%h", e_req, exp_v); end
    e_ack_code = 3'd2; exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL ack2_req got=%h exp=%h", e_req, exp_v); end
    checks++;
    if (e_irq !== 1'b0) begin errors++; $display("FAIL ack2_irq got=%b exp=0", e_irq); end
    // ack on a line that is not pending
    e_ack_code = 3'd7; exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v || e_overflow !== 8'h00) begin
      errors++; $display("FAIL ack_idle got=%h/%h exp=%h/00", e_req, e_overflow, exp_v);
    end
    e_ack = 1'b0;
  endtask

  task automatic test_masking();
    e_mask_we = 1'b1; e_mask_wdata = 8'h0F; exp_q.push_back(8'h0F);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_mask !== exp_v) begin errors++; $display("FAIL mask_write got=%h exp=%h", e_mask, exp_v); end
    e_mask_we = 1'b0; e_irq_in = 8'h40; exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v || e_irq !== 1'b0) begin
      errors++; $display("FAIL masked_req got=%h irq=%b exp=%h irq=0", e_req, e_irq, exp_v);
    end
    e_irq_in = 8'h00; e_mask_we = 1'b1; e_mask_wdata = 8'hFF; exp_q.push_back(8'h40);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL unmask_req got=%h exp=%h", e_req, exp_v); end
    // ack clears a pending line even while it is masked
    e_mask_wdata = 8'h00; e_ack = 1'b1; e_ack_code = 3'd6;
    tick();
    e_ack = 1'b0; e_mask_wdata = 8'hFF; exp_q.push_back(8'h00);
    tick();
    e_mask_we = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL masked_ack got=%h exp=%h", e_req, exp_v); end
  endtask

  task automatic test_overflow();
    e_irq_in = 8'h08;
    tick();
    e_irq_in = 8'h00;
    tick();
    e_irq_in = 8'h08; exp_q.push_back(8'h08);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_overflow !== exp_v) begin errors++; $display("FAIL overrun got=%h exp=%h", e_overflow, exp_v); end
    e_irq_in = 8'h00;
    tick();
    e_irq_in = 8'h08; e_ack = 1'b1; e_ack_code = 3'd3;
    exp_q.push_back(8'h08); exp_q.push_back(8'h08);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL collide_req got=%h exp=%h", e_req, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (e_overflow !== exp_v) begin errors++; $display("FAIL collide_ovf got=%h exp=%h", e_overflow, exp_v); end
    e_irq_in = 8'h00; exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    tick();
    e_ack = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL clear3_req got=%h exp=%h", e_req, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (e_overflow !== exp_v) begin errors++; $display("FAIL clear3_ovf got=%h exp=%h", e_overflow, exp_v); end
  endtask

  task automatic test_level();
    l_irq_in = 8'h02; exp_q.push_back(8'h02);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (l_req !== exp_v) begin errors++; $display("FAIL level_set got=%h exp=%h", l_req, exp_v); end
    l_ack = 1'b1; l_ack_code = 3'd1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'h02);
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (l_req !== exp_v) begin errors++; $display("FAIL level_hold%0d got=%h exp=%h", k, l_req, exp_v); end
    end
    l_ack = 1'b0; l_irq_in = 8'h00; exp_q.push_back(8'h02);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (l_req !== exp_v) begin errors++; $display("FAIL level_sticky got=%h exp=%h", l_req, exp_v); end
    l_ack = 1'b1; exp_q.push_back(8'h00);
    tick();
    l_ack = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (l_req !== exp_v) begin errors++; $display("FAIL level_clear got=%h exp=%h", l_req, exp_v); end
  endtask

  task automatic test_reset_mid();
    e_irq_in = 8'h81; exp_q.push_back(8'h81);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL pre_reset got=%h exp=%h", e_req, exp_v); end
    e_irq_in = 8'h01; rst_n = 1'b0; exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL mid_reset got=%h exp=%h", e_req, exp_v); end
    rst_n = 1'b1; exp_q.push_back(8'h01);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (e_req !== exp_v) begin errors++; $display("FAIL held_high got=%h exp=%h", e_req, exp_v); end
    e_irq_in = 8'h00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_capture_drain();
    test_masking();
    test_overflow();
    test_level();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending.md
# irq_pending

Interrupt-request capture stage that sits directly upstream of the 8-to-3 priority encoder. It samples eight request lines and latches each request into a sticky pending bit. It gates the pending bits with a software-writable mask and presents the masked vector to the encoder's `in` input. The encoder's 3-bit `code` is returned through the acknowledge port to clear the serviced bit, and overruns are flagged per line.

## Interface
Parameters:
- `EDGE_MODE`, default 1: 1 = rising-edge capture; 0 = level capture.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `irq_in`  in  8  raw request lines, synchronous to `clk`.
- `mask_we`  in  1  mask write strobe.
- `mask_wdata`  in  8  new mask value, written when `mask_we`=1; bit=1 enables the line.
- `ack`  in  1  acknowledge strobe, one cycle per serviced request.
- `ack_code`  in  3  index of the line being acknowledged; normally the encoder's `code`.
- `req`  out  8  `pending & mask`; drives the encoder `in`; combinational from registers.
- `irq`  out  1  `|req`; combinational from registers.
- `mask`  out  8  current mask register.
- `overflow`  out  8  sticky per-line overrun flags.

## Operation
- Registers: `irq_q[7:0]` (previous sample), `pending[7:0]`, `mask[7:0]`, `overflow[7:0]`.
- `irq_q` loads `irq_in` every cycle.
- Set term `set[i]`:
  - `EDGE_MODE`=1: `irq_in[i] & ~irq_q[i]`.
  - `EDGE_MODE`=0: `irq_in[i]`.
- Clear term: `clr[i] = ack & (ack_code == i)`.
- Pending update: `pending[i] <= set[i] | (pending[i] & ~clr[i])`.
  - Set wins over a same-cycle clear.
- Overflow update:
  - `overflow[i] <= 1` when `set[i]` and `pending[i]` are both 1 and `clr[i]` is 0.
  - `overflow[i] <= 0` when `clr[i]`=1 and `set[i]`=0.
  - Otherwise `overflow[i]` holds.
- Masking:
  - Capture is independent of the mask; masked lines still latch into `pending`.
  - The mask only gates `req`.
  - Unmasking a pending line asserts its `req` bit immediately.
- Ack rules:
  - Acking a line that is not pending has no effect.
  - Acking a masked but pending line clears it.
  - `ack_code` is ignored when `ack`=0.
- Mask write: `mask <= mask_wdata` when `mask_we`=1. A mask write in the same cycle as a set or ack affects only gating of `req`, never capture.
- Level mode: an acked line whose `irq_in` is still high re-sets in the same cycle. `pending` therefore stays 1 until the source drops.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - `irq_q`=0, `pending`=0, `overflow`=0, `mask`=8'hFF.
  - Hence `req`=0, `irq`=0, `mask`=8'hFF.
  - Reset has priority over every other input, including in the middle of a pending/ack sequence.
- Lines high through reset:
  - Because `irq_q` resets to 0, a line held high across reset release is captured as an edge on the first clock edge with `rst_n`=1.
  - This applies in both modes.
- Capture latency:
  - A 0->1 transition on `irq_in[i]` is sampled at clock edge k.
  - `pending[i]` and `req[i]` are high after edge k, i.e. 1 cycle.
- Ack latency: an `ack` sampled at edge k drops `req[i]` after edge k.
  - The encoder output is combinational, so the next priority `code` is valid in the same cycle.
- Mask latency: a write at edge k affects `req` after edge k.
- Pulses: a one-cycle pulse on `irq_in` is captured. Pulses narrower than one clock period are not guaranteed.
- Outputs `req`, `irq`, `overflow` and `mask` are glitch-free functions of registers.
  - There is no combinational path from any input to any output.

## Test plan
- Reset values:
  - Hold `rst_n`=0 for 3 cycles with `irq_in`=8'h00, then release.
  - Required: `req`=0, `irq`=0, `mask`=8'hFF, `overflow`=0.
- Edge capture and priority drain:
  - Pulse `irq_in`=8'h24 for one cycle.
  - Required: `req`=8'h24 next cycle.
  - Ack code 5 -> `req`=8'h04; ack code 2 -> `req`=0, `irq`=0.
- Masking:
  - Write mask 8'h0F, then edge on bit 6.
  - Required: `req`=0 and `pending[6]`=1.
  - Write mask 8'hFF -> `req`=8'h40 the next cycle.
- Set/clear collision and overflow:
  - Bit 3 pending; new edge on bit 3 with no ack -> `overflow`=8'h08.
  - Edge together with ack code 3 -> `pending[3]` stays 1 and `overflow` is unchanged.
  - Ack code 3 alone -> `pending[3]`=0, `overflow[3]`=0.
- Level mode (`EDGE_MODE`=0):
  - Hold `irq_in[1]`=1 and ack code 1 each cycle.
  - Required: `req[1]` stays 1.
  - Drop the line, then ack -> `req`=0.
- Reset mid-operation and held-high line:
  - With `req`=8'h81, assert `rst_n`=0 for one cycle while `irq_in[0]`=1.
  - Required: `req`=0 in the reset cycle, then `req`=8'h01 after the first edge with `rst_n`=1.
